stack_stream_reverser: RTL and testbench
========================================

# stack_stream_reverser

Initiator for the stack push/pop interface. It accepts a valid/ready word stream, pushes each frame onto an external stack, then pops it back out, so each frame leaves in reverse word order. It sits between a stream producer and consumer and drives the stack's push, pop and push_data ports. The stack it drives is reset by the same reset signal.

## Interface
- B, 8: bits per data word; must match the stack's word width.
- W, 4: stack address bits; maximum frame length is DEPTH = 2**W words.

- clk  in  1  rising-edge clock shared with the stack.
- reset  in  1  synchronous, active-high. Also drives the stack's reset.
- in_valid  in  1  producer word valid.
- in_data  in  B  producer word.
- in_last  in  1  marks the final word of a frame.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  reversed word available.
- out_data  out  B  reversed word, equal to st_pop_data.
- out_last  out  1  marks the final word of a reversed frame.
- out_ready  in  1  consumer accepts out_data.
- st_push  out  1  stack push strobe.
- st_pop  out  1  stack pop strobe.
- st_push_data  out  B  word to push, equal to in_data.
- st_pop_data  in  B  stack top-of-stack word (combinational read).
- st_empty  in  1  stack empty flag.
- st_full  in  1  stack full flag.
- split  out  1  one-cycle pulse when a frame is force-closed at DEPTH words.
- err  out  1  sticky flag: stack flags disagree with the internal count.

## Operation
- Two-state FSM:
  - FILL (the reset state).
  - DRAIN.
- Internal count is W+1 bits wide and resets to 0.
- FILL:
  - in_ready = (count < DEPTH).
  - On in_valid & in_ready: st_push = 1 and count increments.
  - If the accepted word has in_last = 1, go to DRAIN.
  - If the accepted word makes count = DEPTH, go to DRAIN and pulse split. Subsequent input words start a new frame after the drain.
- DRAIN:
  - in_ready = 0, out_valid = 1, out_data = st_pop_data, out_last = (count == 1).
  - On out_ready: st_pop = 1 and count decrements.
  - Popping the word with out_last = 1 returns the FSM to FILL with count = 0.
- st_push and st_pop are never high in the same cycle.
- st_push_data = in_data at all times. It matters only when st_push = 1.
- Every frame holds at least 1 word, because in_last qualifies an accepted word. No empty frames exist.
- err sets and stays set until reset on either condition:
  - st_empty = 1 while in DRAIN.
  - st_full = 1 while in FILL with count < DEPTH.
- Reset mid-frame: the FSM goes to FILL and count to 0. Any partially pushed or partially popped frame is discarded. The stack pointer resets on the same edge.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, st_push = 0, st_pop = 0, split = 0, err = 0.
- in_ready, out_valid and out_last depend only on registered state and count. There is no combinational path from in_valid or out_ready to them.
- st_push = in_valid & in_ready and st_pop = out_valid & out_ready, both combinational.
- out_data is a combinational pass-through of st_pop_data. The stack updates its pointer on the same edge as the pop, so the next word is valid in the following cycle.
- Latency: out_valid rises 1 cycle after the edge that accepts the frame's last word. An N-word frame with out_ready held high drains in N cycles.
- in_ready rises the cycle after the final pop, so back-to-back frames have a 1-cycle turnaround.
- out_valid and out_data hold stable while out_ready = 0.
- split is high during the cycle after the forcing push, which is the first DRAIN cycle.

## Structure
- Package stack_stream_pkg holds:
  - enum state_t {FILL, DRAIN};
  - localparam DEPTH = 2**W, as a helper function of W.
- The RTL is a single module with the FSM, counter and err logic; it has no sub-modules.
- A separate wrapper, stack_stream_reverser_top, instantiates this block plus the stack with shared clk/reset. The bench uses the wrapper for end-to-end tests.

## Test plan
- Frame 0xA1, 0xB2, 0xC3 (last on 0xC3) with out_ready = 1 → output 0xC3, 0xB2, 0xA1 with out_last on 0xA1. in_ready = 0 for 3 cycles, then returns to 1.
- Single-word frame 0x55 with in_last → one output 0x55 with out_last = 1, then back to FILL with in_ready = 1.
- 17 words 0x00..0x10 with no in_last (W = 4) → split pulses once, output 0x0F..0x00 with out_last on 0x00, then 0x10 is accepted as the start of a new frame.
- 4-word frame drained with out_ready toggling 1,0,0,1,1,0,1 → no st_pop while out_ready = 0, out_data held stable, all 4 words in reverse order.
- reset asserted for 1 cycle mid-drain after 2 of 5 words → next cycle out_valid = 0 and in_ready = 1. A new frame 0x11, 0x22 then returns 0x22, 0x11.
- Stub st_empty = 1 during DRAIN (standalone bench) → err = 1 from the next cycle, held until reset.

Source files
------------

// File: rtl/stack_stream_pkg.sv
// Shared types and sizing helpers for the stack stream reverser.
// Provides the FSM state encoding and the stack depth derived from the
// address width.
package stack_stream_pkg;

   localparam int unsigned B_DEFAULT = 8;
   localparam int unsigned W_DEFAULT = 4;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Number of words a stack with w address bits can hold.
   function automatic int unsigned stack_depth(input int unsigned w);
      return 32'(1) << w;
   endfunction

   localparam int unsigned DEPTH_DEFAULT = stack_depth(W_DEFAULT);

endpackage

// File: rtl/stack_stream_reverser_top.sv
// Reverser plus its stack sharing clk and reset.
// Ports: clk, reset, in_* producer stream, out_* consumer stream, split, err.
module stack_stream_reverser_top
   import stack_stream_pkg::*;
#(
   parameter int unsigned B = B_DEFAULT,
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [B-1:0] in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic         out_valid,
   output logic [B-1:0] out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         split,
   output logic         err
);

   logic         st_push;
   logic         st_pop;
   logic [B-1:0] st_push_data;
   logic [B-1:0] st_pop_data;
   logic         st_empty;
   logic         st_full;

   stack_stream_reverser #(.B(B), .W(W)) u_rev (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .st_push      (st_push),
      .st_pop       (st_pop),
      .st_push_data (st_push_data),
      .st_pop_data  (st_pop_data),
      .st_empty     (st_empty),
      .st_full      (st_full),
      .split        (split),
      .err          (err)
   );

   stack_stream_stack #(.B(B), .W(W)) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (st_push),
      .pop       (st_pop),
      .push_data (st_push_data),
      .pop_data  (st_pop_data),
      .empty     (st_empty),
      .full      (st_full)
   );

endmodule

// File: rtl/stack_stream_stack.sv
// LIFO stack with push/pop strobes and a combinational top-of-stack read.
// Ports: clk, reset, push, pop, push_data, pop_data, empty, full.
module stack_stream_stack
   import stack_stream_pkg::*;
#(
   parameter int unsigned B = B_DEFAULT,
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [B-1:0] push_data,
   output logic [B-1:0] pop_data,
   output logic         empty,
   output logic         full
);

   localparam int unsigned DEPTH = stack_depth(W);
   localparam int unsigned CW    = W + 1;

   logic [B-1:0]  mem [DEPTH];
   logic [CW-1:0] ptr;

   assign empty    = (ptr == '0);
   assign full     = (ptr == CW'(DEPTH));
   assign pop_data = mem[W'(ptr - CW'(1))];

   // Stack pointer: push has priority, overflow/underflow are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (push && !full) begin
         ptr <= ptr + CW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr - CW'(1);
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[W'(ptr)] <= push_data;
      end
   end

endmodule

// File: rtl/stack_stream_reverser.sv
// Frame reverser that drives an external LIFO stack.
// Words arriving on the in_* stream are pushed until in_last or until the
// stack is full, then popped onto the out_* stream in reverse order.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready     - producer stream
//   out_valid/out_data/out_last/out_ready - consumer stream
//   st_push/st_pop/st_push_data           - stack command strobes and data
//   st_pop_data/st_empty/st_full          - stack top word and flags
//   split                  - pulse: frame force-closed at full depth
//   err                    - sticky: stack flags disagree with count
module stack_stream_reverser
   import stack_stream_pkg::*;
#(
   parameter int unsigned B = B_DEFAULT,
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [B-1:0] in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic         out_valid,
   output logic [B-1:0] out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         st_push,
   output logic         st_pop,
   output logic [B-1:0] st_push_data,
   input  logic [B-1:0] st_pop_data,
   input  logic         st_empty,
   input  logic         st_full,
   output logic         split,
   output logic         err
);

   localparam int unsigned DEPTH = stack_depth(W);
   localparam int unsigned CW    = W + 1;

   state_t        state;
   logic [CW-1:0] count;

   // Handshake signals derive from registered state only.
   assign in_ready     = (state == FILL) && (count < CW'(DEPTH));
   assign out_valid    = (state == DRAIN);
   assign out_last     = (state == DRAIN) && (count == CW'(1));
   assign out_data     = st_pop_data;
   assign st_push      = in_valid & in_ready;
   assign st_pop       = out_valid & out_ready;
   assign st_push_data = in_data;

   // FSM, word counter, split pulse and sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FILL;
         count <= '0;
         split <= 1'b0;
         err   <= 1'b0;
      end else begin
         split <= 1'b0;
         if (((state == DRAIN) && st_empty) ||
             ((state == FILL) && (count < CW'(DEPTH)) && st_full)) begin
            err <= 1'b1;
         end
         case (state)
            FILL: begin
               if (st_push) begin
                  count <= count + CW'(1);
                  if (in_last) begin
                     state <= DRAIN;
                  end else if (count == CW'(DEPTH - 1)) begin
                     // Frame force-closed: the stack cannot take another word.
                     state <= DRAIN;
                     split <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (st_pop) begin
                  if (count == CW'(1)) begin
                     state <= FILL;
                     count <= '0;
                  end else begin
                     count <= count - CW'(1);
                  end
               end
            end
            default: begin
               state <= FILL;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_stream_reverser.sv
// Bench for stack_stream_reverser with a behavioural stack attached.
module tb_stack_stream_reverser;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_ready;
   logic       st_push;
   logic       st_pop;
   logic [7:0] st_push_data;
   logic [7:0] st_pop_data;
   logic       st_empty;
   logic       st_full;
   logic       split;
   logic       err;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural stack with flag overrides.
   logic [7:0] smem [DEPTH];
   int         sp = 0;
   bit         force_empty = 1'b0;
   bit         force_full  = 1'b0;

   assign st_pop_data = (sp > 0) ? smem[(sp > 0) ? sp - 1 : 0] : 8'h00;
   assign st_empty    = force_empty || (sp == 0);
   assign st_full     = force_full || (sp == DEPTH);

   always @(posedge clk) begin
      if (reset) sp <= 0;
      else if (st_push && sp < DEPTH) begin
         smem[sp] <= st_push_data;
         sp <= sp + 1;
      end else if (st_pop && sp > 0) sp <= sp - 1;
   end

   always #5 clk = ~clk;

   stack_stream_reverser #(.B(8), .W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .st_push      (st_push),
      .st_pop       (st_pop),
      .st_push_data (st_push_data),
      .st_pop_data  (st_pop_data),
      .st_empty     (st_empty),
      .st_full      (st_full),
      .split        (split),
      .err          (err)
   );

   logic [7:0] in_w [$];
   bit         in_l [$];
   bit         rdy_pat [$];
   logic [8:0] exp_q [$];
   logic [8:0] got_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: cut the word stream into frames at in_last or DEPTH words,
   // reverse each frame, mark its final output word.
   task automatic build_exp(output int nsplit);
      logic [7:0] frame [$];
      exp_q.delete();
      nsplit = 0;
      foreach (in_w[i]) begin
         frame.push_back(in_w[i]);
         if (in_l[i] || frame.size() == DEPTH) begin
            if (!in_l[i]) nsplit++;
            for (int j = frame.size() - 1; j >= 0; j--)
               exp_q.push_back({(j == 0) ? 1'b1 : 1'b0, frame[j]});
            frame.delete();
         end
      end
   endtask

   // Drive in_w/in_l, drain with rdy_pat, collect outputs and compare.
   task automatic xfer(input int budget, output int busy, output int nsplit, output int lat);
      int         idx, dc, cyc, last_acc, first_out;
      bit         stall, prev_ov;
      logic [7:0] held;
      idx = 0; dc = 0; cyc = 0; busy = 0; nsplit = 0;
      last_acc = -1; first_out = -1; stall = 1'b0; prev_ov = 1'b0; held = 8'h00;
      got_q.delete();
      while ((idx < in_w.size() || got_q.size() < exp_q.size()) && cyc < budget) begin
         @(negedge clk);
         in_valid  = (idx < in_w.size());
         in_data   = in_valid ? in_w[idx] : 8'h00;
         in_last   = in_valid ? in_l[idx] : 1'b0;
         out_ready = out_valid ? rdy_pat[dc % rdy_pat.size()] : 1'b0;
         #1;
         if (stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held);
         end
         if (st_push || st_pop) chk("push_pop_excl", st_push & st_pop, 0);
         if (!out_ready && out_valid) chk("no_pop_stalled", st_pop, 0);
         if (split) chk("split_first_drain", {prev_ov, out_valid}, 2'b01);
         if (st_push) begin
            idx++;
            last_acc = cyc;
         end
         if (out_valid) begin
            busy++;
            dc++;
            if (first_out < 0) first_out = cyc;
            if (out_ready) got_q.push_back({out_last, out_data});
         end
         if (split) nsplit++;
         stall   = out_valid && !out_ready;
         held    = out_data;
         prev_ov = out_valid;
         cyc++;
      end
      lat = first_out - last_acc;
      chk("complete", (idx == in_w.size() && got_q.size() >= exp_q.size()) ? 1 : 0, 1);
      chk("out_count", got_q.size(), exp_q.size());
      foreach (exp_q[i]) if (i < got_q.size()) chk("out_word", got_q[i], exp_q[i]);
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int busy, nsp, lat, exp_split;

      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_st_push", st_push, 0);
      chk("rst_st_pop", st_pop, 0);
      chk("rst_split", split, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;

      // Three-word frame, consumer always ready.
      in_w = '{8'hA1, 8'hB2, 8'hC3};
      in_l = '{1'b0, 1'b0, 1'b1};
      rdy_pat = '{1'b1};
      build_exp(exp_split);
      xfer(200, busy, nsp, lat);
      chk("f3_busy", busy, 3);
      chk("f3_latency", lat, 1);
      chk("f3_split", nsp, exp_split);
      idle_check("f3");

      // Single-word frame.
      in_w = '{8'h55};
      in_l = '{1'b1};
      build_exp(exp_split);
      xfer(200, busy, nsp, lat);
      chk("f1_busy", busy, 1);
      idle_check("f1");

      // 17 words without in_last: forced split at 16, 0x10 starts a new frame.
      in_w.delete(); in_l.delete();
      for (int i = 0; i < 17; i++) begin
         in_w.push_back(8'(i));
         in_l.push_back(1'b0);
      end
      build_exp(exp_split);
      xfer(400, busy, nsp, lat);
      chk("split_model", exp_split, 1);
      chk("split_count", nsp, 1);
      idle_check("split");
      do_reset();

      // Four-word frame, consumer toggling.
      in_w = '{8'h41, 8'h42, 8'h43, 8'h44};
      in_l = '{1'b0, 1'b0, 1'b0, 1'b1};
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      build_exp(exp_split);
      xfer(200, busy, nsp, lat);
      chk("toggle_busy", busy, 7);
      idle_check("toggle");

      // Reset mid-drain after 2 of 5 words.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 8'(8'h30 + i); in_last = (i == 4);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      #1;
      chk("mid_first", {out_last, out_data}, {1'b0, 8'h34});
      @(negedge clk);
      #1;
      chk("mid_second", {out_last, out_data}, {1'b0, 8'h33});
      do_reset();
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      in_w = '{8'h11, 8'h22};
      in_l = '{1'b0, 1'b1};
      rdy_pat = '{1'b1};
      build_exp(exp_split);
      xfer(200, busy, nsp, lat);
      idle_check("post_rst");

      // Randomized frames and consumer backpressure.
      in_w.delete(); in_l.delete(); rdy_pat.delete();
      for (int i = 0; i < 60; i++) begin
         in_w.push_back(8'($urandom));
         in_l.push_back((i == 59) || ($urandom_range(0, 5) == 0));
      end
      for (int i = 0; i < 13; i++) rdy_pat.push_back($urandom_range(0, 3) != 0);
      build_exp(exp_split);
      xfer(2000, busy, nsp, lat);
      chk("rand_split", nsp, exp_split);
      idle_check("rand");
      chk("rand_err", err, 0);

      // st_empty while draining sets err, sticky until reset.
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
      @(negedge clk);
      in_data = 8'h02; in_last = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; force_empty = 1'b1;
      #1;
      chk("err_pre", err, 0);
      chk("err_in_drain", out_valid, 1);
      @(negedge clk);
      force_empty = 1'b0;
      #1;
      chk("err_set", err, 1);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("err_sticky", err, 1);
      chk("err_fill", in_ready, 1);
      do_reset();
      chk("err_clear", err, 0);

      // st_full while filling below depth sets err.
      @(negedge clk);
      force_full = 1'b1;
      #1;
      chk("full_pre", err, 0);
      @(negedge clk);
      force_full = 1'b0;
      #1;
      chk("full_set", err, 1);
      do_reset();
      chk("full_clear", err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
